// File: rtl/execute_md.sv
// EX stage with forwarding muxes, ALU, branch resolution, a multi-cycle signed
// mul/div unit and the EX/MEM pipeline register. StallE holds upstream while mul/div runs.
//
// state | meaning
// IDLE  | no mul/div in flight; a MulDivE op latches operands and stalls
// BUSY  | mul latency / one restoring divide iteration per cycle
// DONE  | sign-corrected result is written into EX/MEM, stall released
module execute_md #(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              ALUSrcE,
  input  logic              BranchE,
  input  logic [2:0]        BranchTypeE,
  input  logic [2:0]        ALUControlE,
  input  logic              MulDivE,
  input  logic [1:0]        MulDivOpE,
  input  logic [XLEN-1:0]   RD1_E,
  input  logic [XLEN-1:0]   RD2_E,
  input  logic [XLEN-1:0]   Imm_Ext_E,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [XLEN-1:0]   ResultW,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  output logic              PCSrcE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              StallE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [REG_AW-1:0] RD_M,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   ALU_ResultM
);
  localparam int SH   = $clog2(XLEN);
  localparam int CMAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] DIV_LOAD = CW'(XLEN - 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d;
  logic [1:0]        op_q, op_d;
  logic              rw_l_q, rw_l_d, mw_l_q, mw_l_d, rs_l_q, rs_l_d;
  logic [REG_AW-1:0] rd_l_q, rd_l_d;
  logic [XLEN-1:0]   pc4_l_q, pc4_l_d;

  logic              rw_m_q, mw_m_q, rs_m_q;
  logic [REG_AW-1:0] rd_m_q;
  logic [XLEN-1:0]   pc4_m_q, wd_m_q, alu_m_q;

  logic [XLEN-1:0] src_a, src_bf, src_b, alu_res, md_res, quo_fix, rem_fix;
  logic            cond, stall;
  logic signed [2*XLEN-1:0] prod;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

  // One restoring step on {rem,quo}; returns the updated {rem,quo}.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] dvs);
    logic [XLEN:0] r2, diff;
    r2   = {rem, quo[XLEN-1]};
    diff = r2 - {1'b0, dvs};
    if (!diff[XLEN]) return {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
    else             return {r2[XLEN-1:0], quo[XLEN-2:0], 1'b0};
  endfunction

  always_comb begin
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_m_q;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   src_bf = ResultW;
      2'b10:   src_bf = alu_m_q;
      default: src_bf = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : src_bf;
  end

  always_comb begin
    case (ALUControlE)
      3'b000:  alu_res = src_a + src_b;
      3'b001:  alu_res = src_a - src_b;
      3'b010:  alu_res = src_a & src_b;
      3'b011:  alu_res = src_a | src_b;
      3'b100:  alu_res = src_a ^ src_b;
      3'b101:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      3'b110:  alu_res = src_a << src_b[SH-1:0];
      default: alu_res = src_a >> src_b[SH-1:0];
    endcase
  end

  always_comb begin
    case (BranchTypeE)
      3'b000:  cond = (src_a == src_bf);
      3'b001:  cond = (src_a != src_bf);
      3'b100:  cond = ($signed(src_a) < $signed(src_bf));
      3'b101:  cond = ($signed(src_a) >= $signed(src_bf));
      3'b110:  cond = (src_a < src_bf);
      3'b111:  cond = (src_a >= src_bf);
      default: cond = 1'b0;
    endcase
  end

  assign PCSrcE    = BranchE & cond & ~MulDivE;
  assign PCTargetE = PCE + Imm_Ext_E;

  assign prod = $signed({{XLEN{a_q[XLEN-1]}}, a_q}) * $signed({{XLEN{b_q[XLEN-1]}}, b_q});

  always_comb begin
    quo_fix = (a_q[XLEN-1] ^ b_q[XLEN-1]) ? -quo_q : quo_q;
    rem_fix = a_q[XLEN-1] ? -rem_q : rem_q;
    // A zero divisor bypasses the iteration result entirely.
    if (b_q == '0) begin
      quo_fix = '1;
      rem_fix = a_q;
    end
    case (op_q)
      2'b00:   md_res = prod[XLEN-1:0];
      2'b01:   md_res = prod[2*XLEN-1:XLEN];
      2'b10:   md_res = quo_fix;
      default: md_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rw_l_d  = rw_l_q;
    mw_l_d  = mw_l_q;
    rs_l_d  = rs_l_q;
    rd_l_d  = rd_l_q;
    pc4_l_d = pc4_l_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (MulDivE) begin
          stall   = 1'b1;
          a_d     = src_a;
          b_d     = src_bf;
          op_d    = MulDivOpE;
          rw_l_d  = RegWriteE;
          mw_l_d  = MemWriteE;
          rs_l_d  = ResultSrcE;
          rd_l_d  = RD_E;
          pc4_l_d = PCPlus4E;
          // The latch cycle already counts as the first divide iteration.
          {rem_d, quo_d} = div_step('0, mag(src_a), mag(src_bf));
          cnt_d   = MulDivOpE[1] ? DIV_LOAD : MUL_LOAD;
          state_d = (cnt_d == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (op_q[1]) {rem_d, quo_d} = div_step(rem_q, quo_q, mag(b_q));
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign StallE = rst & stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rw_l_q  <= 1'b0;
      mw_l_q  <= 1'b0;
      rs_l_q  <= 1'b0;
      rd_l_q  <= '0;
      pc4_l_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rw_l_q  <= rw_l_d;
      mw_l_q  <= mw_l_d;
      rs_l_q  <= rs_l_d;
      rd_l_q  <= rd_l_d;
      pc4_l_q <= pc4_l_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rw_m_q  <= 1'b0;
      mw_m_q  <= 1'b0;
      rs_m_q  <= 1'b0;
      rd_m_q  <= '0;
      pc4_m_q <= '0;
      wd_m_q  <= '0;
      alu_m_q <= '0;
    end else if (stall) begin
      rw_m_q <= 1'b0;
      mw_m_q <= 1'b0;
      rs_m_q <= 1'b0;
      rd_m_q <= '0;
    end else if (state_q == DONE) begin
      rw_m_q  <= rw_l_q;
      mw_m_q  <= mw_l_q;
      rs_m_q  <= rs_l_q;
      rd_m_q  <= rd_l_q;
      pc4_m_q <= pc4_l_q;
      wd_m_q  <= b_q;
      alu_m_q <= md_res;
    end else begin
      rw_m_q  <= RegWriteE;
      mw_m_q  <= MemWriteE;
      rs_m_q  <= ResultSrcE;
      rd_m_q  <= RD_E;
      pc4_m_q <= PCPlus4E;
      wd_m_q  <= src_bf;
      alu_m_q <= alu_res;
    end
  end

  assign RegWriteM   = rw_m_q;
  assign MemWriteM   = mw_m_q;
  assign ResultSrcM  = rs_m_q;
  assign RD_M        = rd_m_q;
  assign PCPlus4M    = pc4_m_q;
  assign WriteDataM  = wd_m_q;
  assign ALU_ResultM = alu_m_q;
endmodule

// File: tb/tb_execute_md.sv
// Scoreboard bench for execute_md: expectations are queued at issue and popped
// when the EX/MEM register presents the result.
module tb_execute_md;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int MUL_CYCLES = 2;

  logic clk = 1'b0;
  logic rst;
  logic RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, MulDivE;
  logic [2:0] BranchTypeE, ALUControlE;
  logic [1:0] MulDivOpE, ForwardA_E, ForwardB_E;
  logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [REG_AW-1:0] RD_E;
  logic PCSrcE, StallE, RegWriteM, MemWriteM, ResultSrcM;
  logic [XLEN-1:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
  logic [REG_AW-1:0] RD_M;

  execute_md #(.XLEN(XLEN), .REG_AW(REG_AW), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
    .ALUControlE(ALUControlE), .MulDivE(MulDivE), .MulDivOpE(MulDivOpE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ResultW(ResultW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic        rw;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  task automatic set_ex(input logic [2:0] aluc, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic md, input logic [1:0] mdop);
    RegWriteE = 1'b1; MemWriteE = 1'b0; ResultSrcE = 1'b0; ALUSrcE = 1'b0;
    BranchE = 1'b0; BranchTypeE = 3'b000; ALUControlE = aluc;
    MulDivE = md; MulDivOpE = mdop; RD1_E = a; RD2_E = b; Imm_Ext_E = '0;
    PCE = '0; PCPlus4E = 32'h40; RD_E = rd; ResultW = '0;
    ForwardA_E = 2'b00; ForwardB_E = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 1'b1; ALUSrcE = $urandom_range(0, 1);
    BranchE = 1'b1; BranchTypeE = 3'($urandom); ALUControlE = 3'($urandom);
    MulDivE = 1'b1; MulDivOpE = 2'($urandom); RD1_E = $urandom; RD2_E = $urandom;
    Imm_Ext_E = $urandom; PCE = $urandom; PCPlus4E = $urandom; RD_E = 5'($urandom);
    ResultW = $urandom; ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom);
    @(posedge clk); #1;
    checks++;
    if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rw=%b mw=%b rs=%b rd=%0d pc4=%h wd=%h alu=%h expected all 0",
               RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM);
    end
    checks++;
    if (StallE !== 1'b0) begin
      failures++; $display("FAIL reset_stall got %b expected 0", StallE);
    end
    @(negedge clk);
    rst = 1'b1;
    set_ex(3'd0, 32'd3, 32'd4, 5'd1, 1'b0, 2'b00);
    sb.push_back('{alu: 32'd7, rw: 1'b1, rd: 5'd1});
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (ALU_ResultM !== e.alu || RegWriteM !== e.rw || RD_M !== e.rd) begin
      failures++;
      $display("FAIL reset_add got alu=%h rw=%b rd=%0d expected alu=%h rw=%b rd=%0d",
               ALU_ResultM, RegWriteM, RD_M, e.alu, e.rw, e.rd);
    end
  endtask

  task automatic test_forward();
    logic [31:0] wd_exp;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wd_exp = 32'd0;
      case (i)
        0, 2: begin
          set_ex(3'd0, 32'd2, 32'd3, 5'd2, 1'b0, 2'b00);
          sb.push_back('{alu: 32'd5, rw: 1'b1, rd: 5'd2}); wd_exp = 32'd3;
        end
        1: begin
          set_ex(3'd1, 32'hAAAA, 32'd7, 5'd3, 1'b0, 2'b00); ForwardA_E = 2'b10;
          sb.push_back('{alu: 32'hFFFFFFFE, rw: 1'b1, rd: 5'd3}); wd_exp = 32'd7;
        end
        3: begin
          set_ex(3'd0, 32'h1111, 32'h2222, 5'd4, 1'b0, 2'b00);
          ForwardA_E = 2'b10; ForwardB_E = 2'b01; ResultW = 32'd9;
          sb.push_back('{alu: 32'd14, rw: 1'b1, rd: 5'd4}); wd_exp = 32'd9;
        end
        default: begin
          set_ex(3'd0, 32'd10, 32'd20, 5'd5, 1'b0, 2'b00);
          ForwardA_E = 2'b11; ForwardB_E = 2'b11; ResultW = 32'd1000;
          sb.push_back('{alu: 32'd30, rw: 1'b1, rd: 5'd5}); wd_exp = 32'd20;
        end
      endcase
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (ALU_ResultM !== e.alu || RegWriteM !== e.rw || RD_M !== e.rd) begin
        failures++;
        $display("FAIL forward_%0d got alu=%h rw=%b rd=%0d expected alu=%h rw=%b rd=%0d",
                 i, ALU_ResultM, RegWriteM, RD_M, e.alu, e.rw, e.rd);
      end
      checks++;
      if (WriteDataM !== wd_exp) begin
        failures++; $display("FAIL forward_wd_%0d got %h expected %h", i, WriteDataM, wd_exp);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] a, b;
    a = 32'h80000F0F;
    b = 32'h00000024;
    for (int op = 0; op < 9; op++) begin
      @(negedge clk);
      set_ex(3'(op), a, b, 5'(op + 8), 1'b0, 2'b00);
      if (op == 8) begin
        ALUControlE = 3'd6; ALUSrcE = 1'b1; Imm_Ext_E = 32'd3;
        sb.push_back('{alu: alu_model(3'd6, a, 32'd3), rw: 1'b1, rd: 5'(op + 8)});
      end else begin
        sb.push_back('{alu: alu_model(3'(op), a, b), rw: 1'b1, rd: 5'(op + 8)});
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (ALU_ResultM !== e.alu || RegWriteM !== e.rw || RD_M !== e.rd || WriteDataM !== b) begin
        failures++;
        $display("FAIL alu_op_%0d got alu=%h rw=%b rd=%0d wd=%h expected alu=%h rw=%b rd=%0d wd=%h",
                 op, ALU_ResultM, RegWriteM, RD_M, WriteDataM, e.alu, e.rw, e.rd, b);
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0]  btype [4] = '{3'b100, 3'b110, 3'b001, 3'b101};
    logic [31:0] ra    [4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd5, 32'd5};
    logic [31:0] rb    [4] = '{32'd2, 32'd2, 32'd5, 32'd5};
    logic        taken [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        isrc  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_ex(3'd1, ra[i], rb[i], 5'd0, 1'b0, 2'b00);
      RegWriteE = 1'b0; BranchE = 1'b1; BranchTypeE = btype[i];
      PCE = 32'h100; Imm_Ext_E = 32'h20; ALUSrcE = isrc[i];
      sb.push_back('{alu: isrc[i] ? ra[i] - 32'h20 : ra[i] - rb[i], rw: 1'b0, rd: 5'd0});
      #1;
      checks++;
      if (PCSrcE !== taken[i] || PCTargetE !== 32'h120) begin
        failures++;
        $display("FAIL branch_%0d got taken=%b target=%h expected taken=%b target=%h",
                 i, PCSrcE, PCTargetE, taken[i], 32'h120);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (ALU_ResultM !== e.alu || RegWriteM !== e.rw) begin
        failures++;
        $display("FAIL branch_alu_%0d got alu=%h rw=%b expected alu=%h rw=%b",
                 i, ALU_ResultM, RegWriteM, e.alu, e.rw);
      end
    end
    @(negedge clk);
    set_ex(3'd0, 32'd7, 32'd7, 5'd0, 1'b0, 2'b00);
    BranchE = 1'b0; BranchTypeE = 3'b000;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin
      failures++; $display("FAIL branch_disabled got %b expected 0", PCSrcE);
    end
  endtask

  task automatic test_mul();
    int n;
    logic bubble_ok;
    logic [1:0]  ops  [2] = '{2'b00, 2'b01};
    logic [31:0] expv [2] = '{32'hFFFFFFFD, 32'hFFFFFFFF};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_ex(3'd0, 32'hFFFFFFFF, 32'd3, 5'd7, 1'b1, ops[i]);
      sb.push_back('{alu: expv[i], rw: 1'b1, rd: 5'd7});
      #1;
      n = 0; bubble_ok = 1'b1;
      while (StallE === 1'b1 && n < 200) begin
        n++;
        @(posedge clk); #1;
        if (RegWriteM !== 1'b0 || RD_M !== 5'd0) bubble_ok = 1'b0;
      end
      checks++;
      if (n != MUL_CYCLES) begin
        failures++; $display("FAIL mul_stall_%0d got %0d cycles expected %0d", i, n, MUL_CYCLES);
      end
      checks++;
      if (!bubble_ok) begin
        failures++; $display("FAIL mul_bubble_%0d got a non-bubble during stall expected rw=0 rd=0", i);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (ALU_ResultM !== e.alu || RegWriteM !== e.rw || RD_M !== e.rd) begin
        failures++;
        $display("FAIL mul_result_%0d got alu=%h rw=%b rd=%0d expected alu=%h rw=%b rd=%0d",
                 i, ALU_ResultM, RegWriteM, RD_M, e.alu, e.rw, e.rd);
      end
    end
  endtask

  task automatic test_div();
    int n;
    logic bubble_ok;
    logic [1:0]  ops  [6] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
    logic [31:0] av   [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bv   [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] expv [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_ex(3'd0, av[i], bv[i], 5'(i + 20), 1'b1, ops[i]);
      sb.push_back('{alu: expv[i], rw: 1'b1, rd: 5'(i + 20)});
      #1;
      n = 0; bubble_ok = 1'b1;
      while (StallE === 1'b1 && n < 200) begin
        n++;
        @(posedge clk); #1;
        if (RegWriteM !== 1'b0) bubble_ok = 1'b0;
      end
      checks++;
      if (n != XLEN || !bubble_ok) begin
        failures++;
        $display("FAIL div_stall_%0d got %0d cycles bubble_ok=%b expected %0d bubble_ok=1", i, n, bubble_ok, XLEN);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (ALU_ResultM !== e.alu || RegWriteM !== e.rw || RD_M !== e.rd || WriteDataM !== bv[i]) begin
        failures++;
        $display("FAIL div_result_%0d got alu=%h rw=%b rd=%0d wd=%h expected alu=%h rw=%b rd=%0d wd=%h",
                 i, ALU_ResultM, RegWriteM, RD_M, WriteDataM, e.alu, e.rw, e.rd, bv[i]);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    int n;
    @(negedge clk);
    set_ex(3'd0, 32'd1000, 32'd3, 5'd9, 1'b1, 2'b10);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (StallE !== 1'b1) begin
      failures++; $display("FAIL middiv_busy got stall=%b expected 1", StallE);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (StallE !== 1'b0 || {RegWriteM, MemWriteM, ResultSrcM, RD_M, WriteDataM, ALU_ResultM} !== '0) begin
      failures++;
      $display("FAIL middiv_reset got stall=%b rw=%b rd=%0d alu=%h wd=%h expected all 0",
               StallE, RegWriteM, RD_M, ALU_ResultM, WriteDataM);
    end
    @(negedge clk);
    rst = 1'b1;
    set_ex(3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'b00);
    RegWriteE = 1'b0;
    #1;
    checks++;
    if (StallE !== 1'b0) begin
      failures++; $display("FAIL middiv_idle got stall=%b expected 0", StallE);
    end
    @(negedge clk);
    set_ex(3'd0, 32'd100, 32'd7, 5'd11, 1'b1, 2'b10);
    sb.push_back('{alu: 32'd14, rw: 1'b1, rd: 5'd11});
    #1;
    n = 0;
    while (StallE === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != XLEN) begin
      failures++; $display("FAIL middiv_restall got %0d cycles expected %0d", n, XLEN);
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (ALU_ResultM !== e.alu || RegWriteM !== e.rw || RD_M !== e.rd) begin
      failures++;
      $display("FAIL middiv_result got alu=%h rw=%b rd=%0d expected alu=%h rw=%b rd=%0d",
               ALU_ResultM, RegWriteM, RD_M, e.alu, e.rw, e.rd);
    end
    @(negedge clk);
    set_ex(3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_forward();
    test_alu_ops();
    test_branch();
    test_mul();
    test_div();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
